image_streamer: RTL and testbench

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_streamer.sv | 177 +++++++++++++++++
 tb/tb_image_streamer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_streamer.sv
// image_streamer: streams 28x28 images from pixel memory to a classifier and collects results.
// Optional label scoring is compiled in with `define IMAGE_STREAMER_SCORE_EN.
module image_streamer #(
    parameter int IMG_PIXELS     = 784,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] num_images,
    output logic [15:0] img_addr,
    input  logic [7:0] img_q,
    output logic [7:0] lbl_addr,
    input  logic [3:0] lbl_q,
    output logic [7:0] pixel_o,
    output logic       pixel_o_valid,
    input  logic [3:0] digit_i,
    input  logic       digit_i_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] timeout_count,
    output logic [7:0] correct_count,
    output logic [3:0] last_digit
);

    localparam int PW = $clog2(IMG_PIXELS + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_PIXELS - 1);
    localparam logic [PW-1:0] PIX_END   = PW'(IMG_PIXELS);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        STREAM,
        WAIT,
        NEXT,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    num_r;
    logic [7:0]    idx;
    logic [7:0]    idx_inc;
    logic [PW-1:0] pix;
    logic [WW-1:0] wait_cnt;
    logic [15:0]   base_nx;
    logic          more;
    logic          got_digit;
    logic          wait_exp;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic and status outputs
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        got_digit = 1'b0;
        wait_exp  = 1'b0;
        idx_inc   = idx + 8'd1;
        more      = idx_inc < num_r;
        base_nx   = 16'(idx_inc) * 16'(IMG_PIXELS);
        unique case (state)
            IDLE: begin
                if (start) state_nx = (num_images == 8'd0) ? DONE : STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (pix == PIX_END) state_nx = WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                got_digit = digit_i_valid;
                wait_exp  = !digit_i_valid && (wait_cnt == WAIT_LAST);
                if (got_digit || wait_exp) state_nx = NEXT;
            end
            NEXT: begin
                busy     = 1'b1;
                state_nx = more ? STREAM : DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address generation, pixel qualifier, wait timer and result counters
    always_ff @(posedge clk) begin
        if (rst) begin
            num_r         <= 8'd0;
            idx           <= 8'd0;
            pix           <= '0;
            wait_cnt      <= '0;
            img_addr      <= 16'd0;
            pixel_o_valid <= 1'b0;
            timeout_count <= 8'd0;
            last_digit    <= 4'd0;
        end else begin
            pixel_o_valid <= (state == STREAM) && (pix != PIX_END);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        num_r         <= num_images;
                        idx           <= 8'd0;
                        pix           <= '0;
                        img_addr      <= 16'd0;
                        timeout_count <= 8'd0;
                    end
                end
                STREAM: begin
                    wait_cnt <= '0;
                    if (pix != PIX_END) pix <= pix + PW'(1);
                    if (pix < PIX_LAST) img_addr <= img_addr + 16'd1;
                end
                WAIT: begin
                    if (got_digit) begin
                        last_digit <= digit_i;
                    end else if (wait_exp) begin
                        if (timeout_count != 8'hff)
                            timeout_count <= timeout_count + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                NEXT: begin
                    idx <= idx_inc;
                    if (more) begin
                        pix      <= '0;
                        img_addr <= base_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel data is the memory read-back, forced to zero when not qualified
    assign pixel_o = pixel_o_valid ? img_q : 8'd0;

`ifdef IMAGE_STREAMER_SCORE_EN
    logic [3:0] lbl_r;

    assign lbl_addr = idx;

    // Capture the label once the last pixel has gone out
    always_ff @(posedge clk) begin
        if (rst)
            lbl_r <= 4'd0;
        else if (state == STREAM && pix == PIX_END)
            lbl_r <= lbl_q;
    end

    // Count results that agree with the label
    always_ff @(posedge clk) begin
        if (rst)
            correct_count <= 8'd0;
        else if (state == IDLE && start)
            correct_count <= 8'd0;
        else if (got_digit && digit_i == lbl_r && correct_count != 8'hff)
            correct_count <= correct_count + 8'd1;
    end
`else
    logic unused_lbl;

    assign lbl_addr      = 8'd0;
    assign correct_count = 8'd0;
    assign unused_lbl    = ^lbl_q;
`endif

endmodule

// File: tb/tb_image_streamer.sv
// tb_image_streamer: scoreboard bench for image_streamer.
// Expected pixels are queued at start and popped as pixel_o_valid appears.
module tb_image_streamer;

    localparam int NPIX = 784;
    localparam int TMO  = 100;
`ifdef IMAGE_STREAMER_SCORE_EN
    localparam int EXP_CORRECT = 2;
`else
    localparam int EXP_CORRECT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_images;
    logic [15:0] img_addr;
    logic [7:0]  img_q;
    logic [7:0]  lbl_addr;
    logic [3:0]  lbl_q;
    logic [7:0]  pixel_o;
    logic        pixel_o_valid;
    logic [3:0]  digit_i;
    logic        digit_i_valid;
    logic        busy;
    logic        done;
    logic [7:0]  timeout_count;
    logic [7:0]  correct_count;
    logic [3:0]  last_digit;

    logic [7:0] mem [0:4095];
    logic [3:0] lbl_mem [0:3];
    logic [7:0] exp_q[$];

    int n_chk = 0;
    int n_err = 0;
    int vcnt  = 0;
    int segs  = 0;
    logic prev_v = 1'b0;

    image_streamer #(
        .IMG_PIXELS    (NPIX),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_images   (num_images),
        .img_addr     (img_addr),
        .img_q        (img_q),
        .lbl_addr     (lbl_addr),
        .lbl_q        (lbl_q),
        .pixel_o      (pixel_o),
        .pixel_o_valid(pixel_o_valid),
        .digit_i      (digit_i),
        .digit_i_valid(digit_i_valid),
        .busy         (busy),
        .done         (done),
        .timeout_count(timeout_count),
        .correct_count(correct_count),
        .last_digit   (last_digit)
    );

    always #5 clk = ~clk;

    // Synchronous-read pixel and label memories
    always @(posedge clk) begin
        img_q <= mem[img_addr[11:0]];
        lbl_q <= lbl_mem[lbl_addr[1:0]];
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every qualified pixel
    always @(negedge clk) begin
        if (pixel_o_valid === 1'b1) begin
            vcnt++;
            if (!prev_v) segs++;
            if (exp_q.size() == 0) check("pix_extra", 1, 0);
            else check("pix", pixel_o, exp_q.pop_front());
        end
        prev_v = (pixel_o_valid === 1'b1);
    end

    function automatic logic [63:0] outs();
        return {pixel_o_valid, pixel_o, busy, done, timeout_count,
                correct_count, last_digit, img_addr, lbl_addr};
    endfunction

    task automatic do_start(input int n);
        start      = 1'b1;
        num_images = 8'(n);
        for (int im = 0; im < n; im++)
            for (int p = 0; p < NPIX; p++)
                exp_q.push_back(mem[im * NPIX + p]);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_img_end();
        int n = 0;
        while (pixel_o_valid !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        while (pixel_o_valid === 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("img_end_timeout", 0, 1);
    endtask

    task automatic pulse_digit(input logic [3:0] d);
        digit_i       = d;
        digit_i_valid = 1'b1;
        @(negedge clk);
        digit_i_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
    endtask

    task automatic end_run(input string tag, input int n_img,
                           input int v0, input int s0);
        check({tag, "_nvalid"}, vcnt - v0, n_img * NPIX);
        check({tag, "_segments"}, segs - s0, n_img);
        check({tag, "_queue_left"}, exp_q.size(), 0);
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
    endtask

    logic [3:0] digs [0:2];
    int v0, s0, n, k;

    initial begin
        for (int i = 0; i < 4096; i++)
            mem[i] = 8'((i * 13) ^ (i >> 5));
        lbl_mem[0] = 4'd7;
        lbl_mem[1] = 4'd2;
        lbl_mem[2] = 4'd1;
        lbl_mem[3] = 4'd0;
        digs[0] = 4'd7;
        digs[1] = 4'd3;
        digs[2] = 4'd1;

        rst = 1'b1;
        start = 1'b0;
        num_images = 8'd0;
        digit_i = 4'd0;
        digit_i_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);

        // one image, result 50 cycles after the last pixel
        v0 = vcnt; s0 = segs;
        do_start(1);
        check("one_busy", busy, 1);
        wait_img_end();
        repeat (49) @(negedge clk);
        pulse_digit(4'd4);
        wait_done("one");
        check("one_timeouts", timeout_count, 0);
        check("one_last", last_digit, 4);
        end_run("one", 1, v0, s0);

        // three images with labels 7,2,1 and results 7,3,1
        v0 = vcnt; s0 = segs;
        do_start(3);
        for (int i = 0; i < 3; i++) begin
            wait_img_end();
            repeat (5) @(negedge clk);
            pulse_digit(digs[i]);
        end
        wait_done("three");
        check("three_correct", correct_count, EXP_CORRECT);
        check("three_last", last_digit, 1);
        check("three_addr", img_addr, 2351);
        check("three_timeouts", timeout_count, 0);
        end_run("three", 3, v0, s0);

        // no result: timeout after exactly TMO wait cycles
        v0 = vcnt; s0 = segs;
        do_start(1);
        wait_img_end();
        n = 0;
        while (done !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, TMO + 1);
        check("tmo_count", timeout_count, 1);
        check("tmo_last", last_digit, 1);
        end_run("tmo", 1, v0, s0);

        // result on the final wait cycle wins over the timeout
        v0 = vcnt; s0 = segs;
        do_start(1);
        wait_img_end();
        repeat (TMO - 1) @(negedge clk);
        pulse_digit(4'd6);
        wait_done("edge");
        check("edge_count", timeout_count, 0);
        check("edge_last", last_digit, 6);
        end_run("edge", 1, v0, s0);

        // results outside WAIT are ignored
        pulse_digit(4'd9);
        check("idle_last", last_digit, 6);
        check("idle_tmo", timeout_count, 0);
        check("idle_correct", correct_count, 0);
        v0 = vcnt; s0 = segs;
        do_start(1);
        repeat (100) @(negedge clk);
        pulse_digit(4'd7);
        wait_img_end();
        wait_done("strm");
        check("strm_last", last_digit, 6);
        check("strm_tmo", timeout_count, 1);
        check("strm_correct", correct_count, 0);
        end_run("strm", 1, v0, s0);

        // empty run
        v0 = vcnt;
        do_start(0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        @(negedge clk);
        check("zero_done_width", done, 0);
        check("zero_nvalid", vcnt - v0, 0);

        // reset part-way through an image
        do_start(1);
        n = 0; k = 0;
        while (k < 400 && n < 2000) begin
            @(negedge clk);
            n++;
            if (pixel_o_valid === 1'b1) k++;
        end
        check("mid_reached", k, 400);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", outs(), 0);
        exp_q.delete();
        v0 = vcnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_no_pixels", vcnt - v0, 0);
        s0 = segs;
        do_start(1);
        check("restart_addr", img_addr, 0);
        check("restart_busy", busy, 1);
        wait_img_end();
        pulse_digit(4'd3);
        wait_done("restart");
        check("restart_last", last_digit, 3);
        end_run("restart", 1, v0, s0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
